// File: rtl/vga_text_pkg.sv
// Shared constants, attribute word layout and CGA palette for the text renderer.
package vga_text_pkg;

  localparam int DEF_COLS = 80;
  localparam int DEF_ROWS = 30;
  localparam int GLYPH_W  = 8;
  localparam int GLYPH_H  = 16;

  // Text RAM word: background index, foreground index, glyph code
  typedef struct packed {
    logic [3:0] bg;
    logic [3:0] fg;
    logic [7:0] code;
  } txt_word_t;

  // CGA order, entry 15 first in the concatenation
  localparam logic [15:0][11:0] PALETTE = {
    12'hFFF, 12'hFF5, 12'hF5F, 12'hF55,
    12'h5FF, 12'h5F5, 12'h55F, 12'h555,
    12'hAAA, 12'hA50, 12'hA0A, 12'hA00,
    12'h0AA, 12'h0A0, 12'h00A, 12'h000
  };

endpackage

// File: rtl/vga_cursor_blink.sv
// Cursor blink phase: counts vsync falling edges, toggles every BLINK_FRAMES frames,
// and restarts in the visible phase whenever the cursor moves.
module vga_cursor_blink #(
  parameter int BLINK_FRAMES = 30
) (
  input  logic       pclk,
  input  logic       reset,
  input  logic       i_vsync,
  input  logic [6:0] i_cursor_x,
  input  logic [4:0] i_cursor_y,
  output logic       o_phase
);

  localparam logic [7:0] LAST_CNT = 8'(BLINK_FRAMES - 1);

  logic       r_vs_d;
  logic [6:0] r_cx_d;
  logic [4:0] r_cy_d;
  logic [7:0] r_cnt;
  logic       r_phase;
  logic       w_fall;
  logic       w_move;

  assign w_fall  = r_vs_d & ~i_vsync;
  assign w_move  = (r_cx_d != i_cursor_x) || (r_cy_d != i_cursor_y);
  assign o_phase = r_phase;

  // Tracked through reset too, so releasing reset never looks like a cursor move
  always_ff @(posedge pclk) begin
    r_cx_d <= i_cursor_x;
    r_cy_d <= i_cursor_y;
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      r_vs_d  <= 1'b1;
      r_cnt   <= '0;
      r_phase <= 1'b1;
    end else begin
      r_vs_d <= i_vsync;
      if (w_move) begin
        r_cnt   <= '0;
        r_phase <= 1'b1;
      end else if (w_fall) begin
        if (r_cnt == LAST_CNT) begin
          r_cnt   <= '0;
          r_phase <= ~r_phase;
        end else begin
          r_cnt <= r_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: rtl/vga_text_renderer.sv
// Text console renderer (8x16 glyphs -> 12-bit RGB), 3-cycle pipeline with aligned syncs.
// Define TEXT_SCROLL_EN to add the scroll_row input for circular row scrolling.
module vga_text_renderer
  import vga_text_pkg::*;
#(
  parameter int COLS         = DEF_COLS,
  parameter int ROWS         = DEF_ROWS,
  parameter int BLINK_FRAMES = 30
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [9:0]  h_cnt,
  input  logic [8:0]  v_cnt,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        cursor_en,
  input  logic [6:0]  cursor_x,
  input  logic [4:0]  cursor_y,
`ifdef TEXT_SCROLL_EN
  input  logic [4:0]  scroll_row,
`endif
  output logic [11:0] txt_addr,
  input  logic [15:0] txt_data,
  output logic [11:0] font_addr,
  input  logic [7:0]  font_row,
  output logic [11:0] rgb,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        valid_out
);

  localparam logic [7:0]  COLS_W = 8'(COLS);
  localparam logic [5:0]  ROWS_W = 6'(ROWS);
  localparam logic [11:0] COLS_A = 12'(COLS);

  logic [6:0]  w_col;
  logic [4:0]  w_row;
  logic [4:0]  w_eff_row;
  logic        w_hit;
  logic [11:0] w_txt_addr;
  txt_word_t   w_word;
  logic        w_phase;
  logic        w_pix;

  logic [11:0] r_txt_addr;
  logic [3:0]  r_s0_line;
  logic [2:0]  r_s0_bit;
  logic        r_s0_hit, r_s0_vld, r_s0_hs, r_s0_vs;

  logic [11:0] r_font_addr;
  logic [3:0]  r_s1_fg, r_s1_bg;
  logic [2:0]  r_s1_bit;
  logic        r_s1_hit, r_s1_vld, r_s1_hs, r_s1_vs;

  logic [11:0] r_rgb;
  logic        r_hs, r_vs, r_vld;

  assign w_col = h_cnt[9:3];
  assign w_row = v_cnt[8:4];

`ifdef TEXT_SCROLL_EN
  logic [4:0] w_scroll;
  logic [5:0] w_sum;
  assign w_scroll  = ({1'b0, scroll_row} < ROWS_W) ? scroll_row : 5'd0;
  assign w_sum     = {1'b0, w_row} + {1'b0, w_scroll};
  assign w_eff_row = (w_sum >= ROWS_W) ? 5'(w_sum - ROWS_W) : w_sum[4:0];
`else
  assign w_eff_row = w_row;
`endif

  assign w_txt_addr = {7'd0, w_eff_row} * COLS_A + {5'd0, w_col};

  // Cursor tracks the unscrolled screen cell; off-screen cursor positions never hit
  assign w_hit = cursor_en && ({1'b0, cursor_x} < COLS_W) && ({1'b0, cursor_y} < ROWS_W[4:0] || {1'b0, cursor_y} < ROWS_W)
                 && (w_col == cursor_x) && (w_row == cursor_y);

  assign w_word = txt_word_t'(txt_data);
  assign w_pix  = font_row[3'd7 - r_s1_bit] ^ (r_s1_hit & w_phase);

  vga_cursor_blink #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink (
    .pclk      (pclk),
    .reset     (reset),
    .i_vsync   (vsync_in),
    .i_cursor_x(cursor_x),
    .i_cursor_y(cursor_y),
    .o_phase   (w_phase)
  );

  always_ff @(posedge pclk) begin
    if (reset) begin
      r_txt_addr <= '0;
      r_s0_line  <= '0;
      r_s0_bit   <= '0;
      r_s0_hit   <= 1'b0;
      r_s0_vld   <= 1'b0;
      r_s0_hs    <= 1'b1;
      r_s0_vs    <= 1'b1;
    end else begin
      r_txt_addr <= w_txt_addr;
      r_s0_line  <= v_cnt[3:0];
      r_s0_bit   <= h_cnt[2:0];
      r_s0_hit   <= w_hit;
      r_s0_vld   <= valid_in;
      r_s0_hs    <= hsync_in;
      r_s0_vs    <= vsync_in;
    end
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      r_font_addr <= '0;
      r_s1_fg     <= '0;
      r_s1_bg     <= '0;
      r_s1_bit    <= '0;
      r_s1_hit    <= 1'b0;
      r_s1_vld    <= 1'b0;
      r_s1_hs     <= 1'b1;
      r_s1_vs     <= 1'b1;
    end else begin
      r_font_addr <= {w_word.code, r_s0_line};
      r_s1_fg     <= w_word.fg;
      r_s1_bg     <= w_word.bg;
      r_s1_bit    <= r_s0_bit;
      r_s1_hit    <= r_s0_hit;
      r_s1_vld    <= r_s0_vld;
      r_s1_hs     <= r_s0_hs;
      r_s1_vs     <= r_s0_vs;
    end
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      r_rgb <= '0;
      r_hs  <= 1'b1;
      r_vs  <= 1'b1;
      r_vld <= 1'b0;
    end else begin
      r_rgb <= r_s1_vld ? PALETTE[w_pix ? r_s1_fg : r_s1_bg] : 12'h000;
      r_hs  <= r_s1_hs;
      r_vs  <= r_s1_vs;
      r_vld <= r_s1_vld;
    end
  end

  assign txt_addr  = r_txt_addr;
  assign font_addr = r_font_addr;
  assign rgb       = r_rgb;
  assign hsync_out = r_hs;
  assign vsync_out = r_vs;
  assign valid_out = r_vld;

endmodule

// File: tb/tb_vga_text_renderer.sv
// Bench for vga_text_renderer: random pixels against a per-pixel text console model,
// text RAM and font ROM modelled as memories read through the registered addresses.
module tb_vga_text_renderer;

  localparam int BF = 2;

  logic        pclk = 1'b0;
  logic        reset = 1'b1;
  logic        valid_in = 1'b0;
  logic [9:0]  h_cnt = '0;
  logic [8:0]  v_cnt = '0;
  logic        hsync_in = 1'b1;
  logic        vsync_in = 1'b1;
  logic        cursor_en = 1'b0;
  logic [6:0]  cursor_x = '0;
  logic [4:0]  cursor_y = '0;
  logic [11:0] txt_addr, font_addr, rgb;
  logic [15:0] txt_data;
  logic [7:0]  font_row;
  logic        hsync_out, vsync_out, valid_out;
`ifdef TEXT_SCROLL_EN
  logic [4:0]  scroll_row = '0;
`endif

  always #5 pclk = ~pclk;

  logic [15:0] txt_mem [4096];
  logic [7:0]  font_mem [4096];
  assign txt_data = txt_mem[txt_addr];
  assign font_row = font_mem[font_addr];

  vga_text_renderer #(.COLS(80), .ROWS(30), .BLINK_FRAMES(BF)) dut (
    .pclk(pclk), .reset(reset), .valid_in(valid_in), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .cursor_en(cursor_en),
    .cursor_x(cursor_x), .cursor_y(cursor_y),
`ifdef TEXT_SCROLL_EN
    .scroll_row(scroll_row),
`endif
    .txt_addr(txt_addr), .txt_data(txt_data), .font_addr(font_addr), .font_row(font_row),
    .rgb(rgb), .hsync_out(hsync_out), .vsync_out(vsync_out), .valid_out(valid_out)
  );

  logic [11:0] pal [16] = '{12'h000, 12'h00A, 12'h0A0, 12'h0AA, 12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
                            12'h555, 12'h55F, 12'h5F5, 12'h5FF, 12'hF55, 12'hF5F, 12'hFF5, 12'hFFF};

  typedef struct { int due; logic [11:0] rgb; logic hs; logic vs; logic vld; } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // cursor / scroll settings applied with the next drive
  logic       c_en = 1'b0;
  int         c_x  = 0;
  int         c_y  = 0;
  int         s_row = 0;

  // blink model state
  int   m_cnt = 0;
  logic m_ph  = 1'b1;
  logic m_pvs = 1'b1;
  int   m_pcx = 0;
  int   m_pcy = 0;

  // pixel waiting for the blink phase that will be in force when it is rendered
  logic       p_have = 1'b0;
  int         p_due;
  logic       p_pix, p_hit, p_vld, p_hs, p_vs;
  logic [3:0] p_fg, p_bg;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input int h, input int v, input logic vld, input logic hs, input logic vs);
    int col, row, er, addr, line, b, sr;
    logic [15:0] w;
    logic [7:0]  fr;
    logic        chg, fall, pix;
    exp_t        e;
    @(negedge pclk);
    reset     = 1'b0;
    h_cnt     = 10'(h);
    v_cnt     = 9'(v);
    valid_in  = vld;
    hsync_in  = hs;
    vsync_in  = vs;
    cursor_en = c_en;
    cursor_x  = 7'(c_x);
    cursor_y  = 5'(c_y);
`ifdef TEXT_SCROLL_EN
    scroll_row = 5'(s_row);
`endif
    chg  = (c_x != m_pcx) || (c_y != m_pcy);
    fall = m_pvs && !vs;
    if (chg) begin
      m_cnt = 0;
      m_ph  = 1'b1;
    end else if (fall) begin
      m_cnt++;
      if (m_cnt == BF) begin
        m_cnt = 0;
        m_ph  = !m_ph;
      end
    end
    m_pvs = vs;
    m_pcx = c_x;
    m_pcy = c_y;
    if (p_have) begin
      pix   = p_pix ^ (p_hit && m_ph);
      e.due = p_due;
      e.rgb = p_vld ? pal[pix ? p_fg : p_bg] : 12'h000;
      e.hs  = p_hs;
      e.vs  = p_vs;
      e.vld = p_vld;
      sb.push_back(e);
    end
    col  = h / 8;
    row  = v / 16;
    line = v % 16;
    b    = h % 8;
    er   = row;
`ifdef TEXT_SCROLL_EN
    sr = (s_row < 30) ? s_row : 0;
    er = row + sr;
    if (er >= 30) er = er - 30;
`else
    sr = 0;
`endif
    addr   = (er * 80 + col + sr * 0) % 4096;
    w      = txt_mem[addr];
    fr     = font_mem[(int'(w[7:0]) * 16 + line) % 4096];
    p_pix  = fr[7 - b];
    p_hit  = c_en && (c_x < 80) && (c_y < 30) && (col == c_x) && (row == c_y);
    p_fg   = w[11:8];
    p_bg   = w[15:12];
    p_vld  = vld;
    p_hs   = hs;
    p_vs   = vs;
    p_due  = cyc + 3;
    p_have = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge pclk);
      reset     = 1'b1;
      valid_in  = 1'b0;
      hsync_in  = 1'b1;
      vsync_in  = 1'b1;
      cursor_en = c_en;
      cursor_x  = 7'(c_x);
      cursor_y  = 5'(c_y);
      sb.delete();
      p_have = 1'b0;
      m_cnt  = 0;
      m_ph   = 1'b1;
      m_pvs  = 1'b1;
      m_pcx  = c_x;
      m_pcy  = c_y;
    end
  endtask

  // vsync low for a few lines: one frame edge
  task automatic vs_fall();
    for (int i = 0; i < 3; i++) drive(0, 0, 1'b0, 1'b1, 1'b0);
    idle(3);
  endtask

  // monitor: compares every output the DUT presents against the queued expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge pclk);
      cyc++;
      #1;
      while (sb.size() > 0 && sb[0].due < cyc) begin
        e = sb.pop_front();
        total++;
        bad++;
        $display("FAIL sb_missed: entry due %0d not compared, now %0d", e.due, cyc);
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        chk("sb_rgb", 32'(rgb), 32'(e.rgb));
        chk("sb_hs_vs_vld", {29'd0, hsync_out, vsync_out, valid_out}, {29'd0, e.hs, e.vs, e.vld});
      end
    end
  end

  initial begin
    int h, v;
    for (int i = 0; i < 4096; i++) begin
      txt_mem[i]  = 16'($urandom);
      font_mem[i] = 8'($urandom);
    end
    txt_mem[162]     = 16'h1F41;
    txt_mem[163]     = 16'h1FFF;
    txt_mem[250]     = 16'h0F00;
    font_mem[1043]   = 8'h80;
    font_mem[12'hFF3] = 8'hFF;
    font_mem[3]      = 8'h80;

    c_en = 1'b0; c_x = 2; c_y = 2;
    do_reset(5);
    @(posedge pclk); #1;
    chk("rst_rgb", 32'(rgb), 32'h000);
    chk("rst_hsync", 32'(hsync_out), 32'd1);
    chk("rst_vsync", 32'(vsync_out), 32'd1);
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_txt_addr", 32'(txt_addr), 32'd0);
    chk("rst_font_addr", 32'(font_addr), 32'd0);

    idle(2);
    drive(17, 35, 1'b1, 1'b1, 1'b1);
    @(posedge pclk); #1;
    chk("txt_addr_162", 32'(txt_addr), 32'd162);
    drive(16, 35, 1'b1, 1'b1, 1'b1);
    @(posedge pclk); #1;
    chk("font_addr_1043", 32'(font_addr), 32'd1043);
    chk("valid_not_early", 32'(valid_out), 32'd0);
    drive(24, 35, 1'b0, 1'b1, 1'b1);
    @(posedge pclk); #1;
    chk("rgb_bg1", 32'(rgb), 32'h00A);
    chk("valid_3cyc", 32'(valid_out), 32'd1);
    idle(1);
    @(posedge pclk); #1;
    chk("rgb_fg15", 32'(rgb), 32'hFFF);
    idle(1);
    @(posedge pclk); #1;
    chk("rgb_blank", 32'(rgb), 32'h000);

    // 96-cycle hsync pulse over live pixels
    for (int i = 0; i < 120; i++) begin
      drive($urandom_range(0, 639), $urandom_range(0, 479), 1'b1,
            (i >= 10 && i < 106) ? 1'b0 : 1'b1, 1'b1);
    end

    c_en = 1'b1;
    drive(16, 35, 1'b1, 1'b1, 1'b1);
    idle(2);
    @(posedge pclk); #1;
    chk("cur_inverted", 32'(rgb), 32'h00A);
    vs_fall();
    vs_fall();
    drive(16, 35, 1'b1, 1'b1, 1'b1);
    idle(2);
    @(posedge pclk); #1;
    chk("cur_blink_off", 32'(rgb), 32'hFFF);
    vs_fall();
    c_x = 3;
    drive(24, 35, 1'b1, 1'b1, 1'b1);
    idle(2);
    @(posedge pclk); #1;
    chk("cur_move_shown", 32'(rgb), 32'h00A);
    vs_fall();
    drive(24, 35, 1'b1, 1'b1, 1'b1);
    idle(2);
    @(posedge pclk); #1;
    chk("cur_cnt_restart", 32'(rgb), 32'h00A);

    c_x = 90;
    drive(720, 35, 1'b1, 1'b1, 1'b1);
    idle(2);
    @(posedge pclk); #1;
    chk("cur_x_offscreen", 32'(rgb), 32'hFFF);
    for (int i = 0; i < 8; i++) drive(720 + i, 35, 1'b1, 1'b1, 1'b1);

`ifdef TEXT_SCROLL_EN
    s_row = 29;
    drive(40, 16, 1'b1, 1'b1, 1'b1);
    @(posedge pclk); #1;
    chk("scroll_wrap", 32'(txt_addr), 32'd5);
    s_row = 0;
`endif

    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        c_en = ($urandom_range(0, 3) != 0);
        c_x  = ($urandom_range(0, 3) == 0) ? $urandom_range(78, 127) : $urandom_range(0, 79);
        c_y  = ($urandom_range(0, 3) == 0) ? $urandom_range(28, 31) : $urandom_range(0, 29);
`ifdef TEXT_SCROLL_EN
        s_row = $urandom_range(0, 31);
`endif
      end
      if (i == 1500) do_reset(3);
      case ($urandom_range(0, 9))
        0, 1: begin
          h = c_x * 8 + $urandom_range(0, 7);
          v = c_y * 16 + $urandom_range(0, 15);
        end
        2: begin
          h = $urandom_range(0, 1023);
          v = $urandom_range(0, 511);
        end
        default: begin
          h = $urandom_range(0, 639);
          v = $urandom_range(0, 479);
        end
      endcase
      drive(h, v, ($urandom_range(0, 6) != 0), (i % 100) >= 12, (i % 50) >= 4);
    end

    idle(4);
    repeat (4) @(posedge pclk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
